conv_mem_responder: RTL and testbench
=====================================

// Module: conv_mem_responder
// PURPOSE
//  Memory-side responder for the shared conv-engine bus (mem_sel/mem_w/address_bus/data_bus).
//  Serves combinational-read / clocked-write accesses from the convolution initiator.
//  Provides a host side port (valid/ready) for preload and readback, and bus activity counters.
//  Clears its array after every reset. Sits between the conv engine and the testbench/host loader.
// PARAMETERS
//  ADDR_WIDTH     8    address bus width
//  DATABUS_WIDTH  32   word width on data_bus and host port
//  DEPTH          256  words stored; must be <= 2**ADDR_WIDTH
//  CNT_WIDTH      16   width of activity counters
// PORTS
//  clk              in     1              clock; all state updates on posedge
//  rst              in     1              asynchronous reset, active-high
//  mem_sel          in     1              bus access strobe from initiator
//  mem_w            in     1              1 = bus write, 0 = bus read
//  address_bus      in     ADDR_WIDTH     word address (shared net; never driven here)
//  data_bus         inout  DATABUS_WIDTH  read data out / write data in
//  host_req_valid   in     1              host request valid
//  host_req_ready   out    1              host request accepted when valid&ready
//  host_req_we      in     1              1 = host write
//  host_req_addr    in     ADDR_WIDTH     host word address
//  host_req_wdata   in     DATABUS_WIDTH  host write data
//  host_rsp_valid   out    1              one-cycle pulse; host read data valid
//  host_rsp_rdata   out    DATABUS_WIDTH  host read data
//  init_done        out    1              array clear complete
//  bus_err          out    1              sticky: out-of-range or during-clear bus access
//  rd_count         out    CNT_WIDTH      bus read cycles since reset (wraps)
//  wr_count         out    CNT_WIDTH      bus write cycles since reset (wraps)
// BEHAVIOUR
//  Reset (async): state=CLEAR, clr_ptr=0; init_done=0, host_req_ready=0, host_rsp_valid=0,
//   host_rsp_rdata=0, bus_err=0, rd_count=0, wr_count=0; data_bus=Z.
//  FSM: CLEAR -> SERVE. No other states. rst mid-operation returns to CLEAR and re-clears.
//  CLEAR: each cycle mem[clr_ptr]<=0, clr_ptr++; after DEPTH cycles -> SERVE, init_done<=1.
//   Bus access (mem_sel=1) in CLEAR: not served, data_bus=Z, bus_err<=1. host_req_ready=0.
//  SERVE, bus read (mem_sel=1, mem_w=0): data_bus = mem[address_bus] combinationally, same cycle;
//   initiator samples at the closing posedge; the address may change every cycle. rd_count++ per edge.
//  SERVE, bus write (mem_sel=1, mem_w=1): mem[address_bus] <= data_bus at posedge; wr_count++.
//   data_bus=Z whenever mem_sel=0, mem_w=1, or state=CLEAR.
//  Out of range (address_bus >= DEPTH): read drives all-zero, write dropped, bus_err<=1.
//  Host port: host_req_ready = init_done & ~mem_sel (bus has absolute priority, no host starvation
//   guard). Accept on valid&ready. Write: mem[addr]<=wdata same edge. Read: host_rsp_valid=1
//   and host_rsp_rdata=mem[addr] the next cycle. Back-to-back reads: one response per cycle.
//   No response backpressure. Out-of-range host write dropped. Out-of-range host read returns 0.
//   Host out-of-range accesses do not set bus_err.
//  Write ordering: a host write and a bus write never collide because ready is gated by mem_sel.
//   Host read of an address written by the bus in the same cycle returns the old value.
//  Counters wrap modulo 2**CNT_WIDTH. bus_err is cleared only by rst.
// STRUCTURE
//  Package conv_mem_pkg: resp_state_t {CLEAR, SERVE}, bus-width localparams shared with the
//   conv engine.
//  Sub-module conv_mem_array: DEPTH x DATABUS_WIDTH storage with one async read port (bus),
//   one registered read port (host), and one write port (muxed: clear/bus/host).
//  Top level holds the FSM, tri-state driver, arbitration, counters and error flag.
// TESTING
//  1 rst pulse, 256 clocks -> init_done rises exactly at cycle 256; host reads of 0x00 and 0xFF
//    return 0.
//  2 mem_sel=1 during CLEAR -> data_bus=Z, bus_err=1 and held after init_done.
//  3 host writes 0x11..0x20 to addr 0x10..0x1F, then bus reads addr 0x10..0x1F on consecutive
//    cycles -> data_bus = 0x11..0x20 same cycle; rd_count=16.
//  4 bus write 0xDEADBEEF to 0x40 with host read of 0x40 requested -> ready=0 that cycle;
//    next-cycle host read returns 0xDEADBEEF; wr_count=1.
//  5 DEPTH=200: bus read at 0xF0 -> data_bus=0, bus_err=1; bus write at 0xF0 -> no array change.
//  6 full conv engine (4x4 matrix, 2x2 kernel) preloaded via host port -> 9 bus writes, and results
//    read back match the golden sums; rst asserted mid-run -> re-CLEAR, counters=0.

Source files
------------

// File: rtl/conv_mem_pkg.sv
// conv_mem_pkg: responder state type and bus-width constants shared with the conv engine
package conv_mem_pkg;
  typedef enum logic {CLEAR, SERVE} resp_state_t;
  localparam int BUS_ADDR_WIDTH = 8;
  localparam int BUS_DATA_WIDTH = 32;
  localparam int BUS_DEPTH = 256;
  localparam int BUS_CNT_WIDTH = 16;
endpackage

// File: rtl/conv_mem_array.sv
// conv_mem_array: DEPTH x DATABUS_WIDTH word store for the conv memory responder
//  clk, rst              clock; async active-high reset (host read register only)
//  we, waddr, wdata      single write port, muxed upstream between clear/bus/host
//  bus_addr, bus_rdata   asynchronous read port for the shared bus (zero when out of range)
//  host_re, host_addr    registered read port for the host
//  host_rdata            host read data, valid the cycle after host_re (zero when out of range)
module conv_mem_array
  import conv_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = BUS_ADDR_WIDTH,
  parameter int DATABUS_WIDTH = BUS_DATA_WIDTH,
  parameter int DEPTH = BUS_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_WIDTH-1:0]    waddr,
  input  logic [DATABUS_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0]    bus_addr,
  output logic [DATABUS_WIDTH-1:0] bus_rdata,
  input  logic                     host_re,
  input  logic [ADDR_WIDTH-1:0]    host_addr,
  output logic [DATABUS_WIDTH-1:0] host_rdata
);
  localparam logic [ADDR_WIDTH:0] LIM = (ADDR_WIDTH+1)'(DEPTH);
  logic [DATABUS_WIDTH-1:0] mem [DEPTH];
  logic bus_ok, host_ok;
  assign bus_ok = {1'b0, bus_addr} < LIM;
  assign host_ok = {1'b0, host_addr} < LIM;
  assign bus_rdata = bus_ok ? mem[bus_addr] : '0;
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // registered read samples pre-edge contents, so a same-edge write is not visible
  always_ff @(posedge clk or posedge rst)
    if (rst) host_rdata <= '0;
    else if (host_re) host_rdata <= host_ok ? mem[host_addr] : '0;
endmodule

// File: rtl/conv_mem_responder.sv
// conv_mem_responder: memory-side responder on the conv-engine bus with host preload/readback port
//  mem_sel, mem_w, address_bus, data_bus   shared initiator bus (comb read, clocked write)
//  host_req_*/host_rsp_*                   host valid/ready port, one-cycle read response
//  init_done                               array clear finished after reset
//  bus_err                                 sticky out-of-range or during-clear bus access
//  rd_count, wr_count                      wrapping bus read/write cycle counters
module conv_mem_responder
  import conv_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = BUS_ADDR_WIDTH,
  parameter int DATABUS_WIDTH = BUS_DATA_WIDTH,
  parameter int DEPTH = BUS_DEPTH,
  parameter int CNT_WIDTH = BUS_CNT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_sel,
  input  logic                     mem_w,
  input  logic [ADDR_WIDTH-1:0]    address_bus,
  inout  wire  [DATABUS_WIDTH-1:0] data_bus,
  input  logic                     host_req_valid,
  output logic                     host_req_ready,
  input  logic                     host_req_we,
  input  logic [ADDR_WIDTH-1:0]    host_req_addr,
  input  logic [DATABUS_WIDTH-1:0] host_req_wdata,
  output logic                     host_rsp_valid,
  output logic [DATABUS_WIDTH-1:0] host_rsp_rdata,
  output logic                     init_done,
  output logic                     bus_err,
  output logic [CNT_WIDTH-1:0]     rd_count,
  output logic [CNT_WIDTH-1:0]     wr_count
);
  localparam logic [ADDR_WIDTH:0] LIM = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  resp_state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] clr_ptr, waddr;
  logic [DATABUS_WIDTH-1:0] wdata, bus_rdata;
  logic serve, bus_ok, host_ok, bus_rd, bus_wr, host_acc, host_re, we;
  assign host_req_ready = init_done & ~mem_sel;
  assign data_bus = bus_rd ? bus_rdata : 'z;
  always_comb begin
    state_nx = (state == CLEAR && clr_ptr == LAST) ? SERVE : state;
    serve = state == SERVE;
    bus_ok = {1'b0, address_bus} < LIM;
    host_ok = {1'b0, host_req_addr} < LIM;
    bus_rd = serve & mem_sel & ~mem_w;
    bus_wr = serve & mem_sel & mem_w;
    host_acc = host_req_valid & host_req_ready;
    host_re = host_acc & ~host_req_we;
    // clear owns the port in CLEAR; afterwards the bus wins, and host is only accepted with mem_sel low
    we = ~serve | (bus_wr & bus_ok) | (host_acc & host_req_we & host_ok);
    waddr = ~serve ? clr_ptr : mem_sel ? address_bus : host_req_addr;
    wdata = ~serve ? '0 : mem_sel ? data_bus : host_req_wdata;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= CLEAR;
      clr_ptr <= '0;
      init_done <= 1'b0;
      host_rsp_valid <= 1'b0;
      bus_err <= 1'b0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      state <= state_nx;
      clr_ptr <= serve ? clr_ptr : clr_ptr + 1'b1;
      init_done <= state_nx == SERVE;
      host_rsp_valid <= host_re;
      bus_err <= bus_err | (mem_sel & (~serve | ~bus_ok));
      rd_count <= rd_count + CNT_WIDTH'(bus_rd);
      wr_count <= wr_count + CNT_WIDTH'(bus_wr);
    end
  conv_mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATABUS_WIDTH(DATABUS_WIDTH),
    .DEPTH(DEPTH)
  ) u_array (
    .clk(clk),
    .rst(rst),
    .we(we),
    .waddr(waddr),
    .wdata(wdata),
    .bus_addr(address_bus),
    .bus_rdata(bus_rdata),
    .host_re(host_re),
    .host_addr(host_req_addr),
    .host_rdata(host_rsp_rdata)
  );
endmodule

// File: tb/tb_conv_mem_responder.sv
// tb_conv_mem_responder: directed table-driven bench for conv_mem_responder (DEPTH 256 and 200)
module tb_conv_mem_responder;
  logic clk = 1'b0;
  logic rst;
  logic mem_sel, mem_w, tb_drv;
  logic [7:0] address_bus;
  logic [31:0] tb_data;
  tri1 [31:0] data_bus;
  tri1 [31:0] data_bus2;
  logic host_req_valid, host_req_we;
  logic [7:0] host_req_addr;
  logic [31:0] host_req_wdata;
  logic ready, rsp_valid, init_done, bus_err;
  logic [31:0] rsp_rdata;
  logic [15:0] rd_count, wr_count;
  logic ready2, rsp_valid2, init_done2, bus_err2;
  logic [31:0] rsp_rdata2;
  logic [15:0] rd_count2, wr_count2;
  int total = 0, bad = 0, rd_e = 0, wr_e = 0;
  typedef struct {
    int op;
    logic [7:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t tv[34];
  always #5 clk = ~clk;
  assign data_bus = tb_drv ? tb_data : 'z;
  assign data_bus2 = tb_drv ? tb_data : 'z;
  conv_mem_responder dut (
    .clk(clk), .rst(rst), .mem_sel(mem_sel), .mem_w(mem_w), .address_bus(address_bus),
    .data_bus(data_bus), .host_req_valid(host_req_valid), .host_req_ready(ready),
    .host_req_we(host_req_we), .host_req_addr(host_req_addr), .host_req_wdata(host_req_wdata),
    .host_rsp_valid(rsp_valid), .host_rsp_rdata(rsp_rdata), .init_done(init_done),
    .bus_err(bus_err), .rd_count(rd_count), .wr_count(wr_count)
  );
  conv_mem_responder #(.DEPTH(200)) dut2 (
    .clk(clk), .rst(rst), .mem_sel(mem_sel), .mem_w(mem_w), .address_bus(address_bus),
    .data_bus(data_bus2), .host_req_valid(host_req_valid), .host_req_ready(ready2),
    .host_req_we(host_req_we), .host_req_addr(host_req_addr), .host_req_wdata(host_req_wdata),
    .host_rsp_valid(rsp_valid2), .host_rsp_rdata(rsp_rdata2), .init_done(init_done2),
    .bus_err(bus_err2), .rd_count(rd_count2), .wr_count(wr_count2)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic host_op(input logic w, input logic [7:0] a, input logic [31:0] d);
    host_req_valid = 1'b1; host_req_we = w; host_req_addr = a; host_req_wdata = d;
    @(negedge clk);
    host_req_valid = 1'b0; host_req_we = 1'b0;
  endtask
  task automatic bus_op(input logic w, input logic [7:0] a, input logic [31:0] d,
                        output logic [31:0] q, output logic [31:0] q2);
    mem_sel = 1'b1; mem_w = w; address_bus = a; tb_drv = w; tb_data = d;
    #1 q = data_bus; q2 = data_bus2;
    if (w) wr_e++; else rd_e++;
    @(negedge clk);
    mem_sel = 1'b0; mem_w = 1'b0; tb_drv = 1'b0;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] q, q2, acc, mv;
    logic [31:0] m[16];
    logic [31:0] k[4];
    logic [31:0] gold;
    for (int i = 0; i < 2; i++) tv[i] = '{1, (i == 0) ? 8'h00 : 8'hFF, 32'h0, 32'h0};
    for (int i = 0; i < 16; i++) tv[2 + i] = '{0, 8'(8'h10 + i), 32'(32'h11 + i), 32'h0};
    for (int i = 0; i < 16; i++) tv[18 + i] = '{3, 8'(8'h10 + i), 32'h0, 32'(32'h11 + i)};
    for (int i = 0; i < 16; i++) m[i] = 32'(3 * i + 1);
    for (int i = 0; i < 4; i++) k[i] = 32'(i + 1);
    rst = 1'b1; mem_sel = 1'b0; mem_w = 1'b0; tb_drv = 1'b0; tb_data = '0; address_bus = '0;
    host_req_valid = 1'b0; host_req_we = 1'b0; host_req_addr = '0; host_req_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst init_done", 32'(init_done), 0);
    chk("rst ready", 32'(ready), 0);
    chk("rst rsp_valid", 32'(rsp_valid), 0);
    chk("rst rsp_rdata", rsp_rdata, 0);
    chk("rst bus_err", 32'(bus_err), 0);
    chk("rst rd_count", 32'(rd_count), 0);
    chk("rst wr_count", 32'(wr_count), 0);
    chk("rst data_bus Z", data_bus, 32'hFFFFFFFF);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    mem_sel = 1'b1; address_bus = 8'h05;
    #1 chk("clear data_bus Z", data_bus, 32'hFFFFFFFF);
    chk("clear ready", 32'(ready), 0);
    @(negedge clk);
    mem_sel = 1'b0;
    chk("clear bus_err", 32'(bus_err), 1);
    chk("clear rd_count", 32'(rd_count), 0);
    repeat (244) @(negedge clk);
    chk("init_done at 255", 32'(init_done), 0);
    chk("d200 init_done", 32'(init_done2), 1);
    @(negedge clk);
    chk("init_done at 256", 32'(init_done), 1);
    chk("bus_err held", 32'(bus_err), 1);
    chk("serve ready", 32'(ready), 1);
    for (int i = 0; i < 34; i++)
      case (tv[i].op)
        0: host_op(1'b1, tv[i].addr, tv[i].wdata);
        1: begin
          host_op(1'b0, tv[i].addr, 32'h0);
          chk("host_rd valid", 32'(rsp_valid), 1);
          chk("host_rd data", rsp_rdata, tv[i].exp);
        end
        2: bus_op(1'b1, tv[i].addr, tv[i].wdata, q, q2);
        default: begin
          bus_op(1'b0, tv[i].addr, 32'h0, q, q2);
          chk("bus_rd data", q, tv[i].exp);
        end
      endcase
    chk("rsp_valid idle", 32'(rsp_valid), 0);
    chk("rd_count 16", 32'(rd_count), 16);
    mem_sel = 1'b1; mem_w = 1'b1; address_bus = 8'h40; tb_drv = 1'b1; tb_data = 32'hDEADBEEF;
    host_req_valid = 1'b1; host_req_we = 1'b0; host_req_addr = 8'h40;
    #1 chk("ready gated by bus", 32'(ready), 0);
    wr_e++;
    @(negedge clk);
    chk("no rsp while gated", 32'(rsp_valid), 0);
    mem_sel = 1'b0; mem_w = 1'b0; tb_drv = 1'b0;
    @(negedge clk);
    host_req_valid = 1'b0;
    chk("host rd after bus wr valid", 32'(rsp_valid), 1);
    chk("host rd after bus wr", rsp_rdata, 32'hDEADBEEF);
    chk("wr_count 1", 32'(wr_count), 1);
    for (int i = 0; i < 16; i++) host_op(1'b1, 8'(i), m[i]);
    for (int i = 0; i < 4; i++) host_op(1'b1, 8'(8'h10 + i), k[i]);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        acc = 0;
        for (int i = 0; i < 2; i++)
          for (int j = 0; j < 2; j++) begin
            bus_op(1'b0, 8'((r + i) * 4 + c + j), 32'h0, q, q2);
            mv = q;
            bus_op(1'b0, 8'(8'h10 + i * 2 + j), 32'h0, q, q2);
            acc = acc + mv * q;
          end
        bus_op(1'b1, 8'(8'h20 + r * 3 + c), acc, q, q2);
      end
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        gold = 0;
        for (int i = 0; i < 2; i++)
          for (int j = 0; j < 2; j++) gold = gold + m[(r + i) * 4 + c + j] * k[i * 2 + j];
        host_op(1'b0, 8'(8'h20 + r * 3 + c), 32'h0);
        chk("conv result", rsp_rdata, gold);
      end
    chk("conv wr_count", 32'(wr_count), 32'(wr_e));
    chk("conv rd_count", 32'(rd_count), 32'(rd_e));
    for (int i = 0; i < 5; i++) bus_op(1'b0, 8'(i), 32'h0, q, q2);
    mem_sel = 1'b1; address_bus = 8'h05;
    #2 rst = 1'b1;
    #1 chk("midrst rd_count", 32'(rd_count), 0);
    chk("midrst wr_count", 32'(wr_count), 0);
    chk("midrst init_done", 32'(init_done), 0);
    chk("midrst ready", 32'(ready), 0);
    chk("midrst data_bus Z", data_bus, 32'hFFFFFFFF);
    @(negedge clk);
    rst = 1'b0; mem_sel = 1'b0; rd_e = 0; wr_e = 0;
    repeat (255) @(negedge clk);
    chk("reclear init_done 255", 32'(init_done), 0);
    @(negedge clk);
    chk("reclear init_done 256", 32'(init_done), 1);
    chk("reclear bus_err", 32'(bus_err), 0);
    chk("reclear d200 bus_err", 32'(bus_err2), 0);
    host_op(1'b0, 8'h20, 32'h0);
    chk("reclear result", rsp_rdata, 0);
    host_op(1'b0, 8'h10, 32'h0);
    chk("reclear kernel", rsp_rdata, 0);
    bus_op(1'b0, 8'hF0, 32'h0, q, q2);
    chk("oor rd d200", q2, 0);
    chk("inrange rd d256", q, 0);
    chk("oor bus_err d200", 32'(bus_err2), 1);
    chk("inrange bus_err d256", 32'(bus_err), 0);
    bus_op(1'b1, 8'hF0, 32'h12345678, q, q2);
    bus_op(1'b0, 8'hF0, 32'h0, q, q2);
    chk("wr d256 visible", q, 32'h12345678);
    chk("oor wr d200 dropped", q2, 0);
    host_op(1'b0, 8'hF0, 32'h0);
    chk("host rd d256", rsp_rdata, 32'h12345678);
    chk("host oor rd d200 valid", 32'(rsp_valid2), 1);
    chk("host oor rd d200", rsp_rdata2, 0);
    host_op(1'b0, 8'h28, 32'h0);
    chk("d200 alias untouched", rsp_rdata2, 0);
    host_op(1'b1, 8'hF8, 32'h5);
    chk("host oor no bus_err", 32'(bus_err), 0);
    chk("final rd_count", 32'(rd_count), 32'(rd_e));
    chk("final wr_count", 32'(wr_count), 32'(wr_e));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
